// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter that lets N_REQ requesters share one WIDTH-bit
//   storage register. Each requester raises REQ with its data slice held
//   stable. The arbiter grants one requester at a time, captures that
//   requester's data into Q and pulses ACK for one cycle. The requester
//   drops REQ to finish the four-phase handshake.
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET    in   synchronous active-high reset
//   REQ      in   [N_REQ]        per-requester write request
//   DATA     in   [N_REQ*WIDTH]  requester data, slice i*WIDTH +: WIDTH
//   GNT      out  [N_REQ]        registered one-hot grant
//   ACK      out  [N_REQ]        registered one-cycle write-done pulse
//   Q        out  [WIDTH]        shared register contents
//   Q_VALID  out  sticky, set by the first completed write after reset
//   BUSY     out  high while the FSM is not in IDLE
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] DATA,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       ACK,
  output logic [WIDTH-1:0]       Q,
  output logic                   Q_VALID,
  output logic                   BUSY
);

  localparam int          IDXW = $clog2(N_REQ);
  localparam int unsigned NR   = N_REQ;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   sel_q,   sel_d;
  logic [IDXW-1:0]   ptr_q,   ptr_d;
  logic [N_REQ-1:0]  gnt_q,   gnt_d;
  logic [N_REQ-1:0]  ack_q,   ack_d;
  logic [WIDTH-1:0]  q_q,     q_d;
  logic              qv_q,    qv_d;
  logic              busy_q,  busy_d;

  // Round-robin search: first set REQ bit starting at ptr_q and wrapping.
  logic              found;
  logic [IDXW-1:0]   pick;
  logic [IDXW-1:0]   idx;
  int unsigned       sum;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    sum   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NR) begin
        sum = sum - NR;
      end
      idx = IDXW'(sum);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    ack_d   = '0;
    q_d     = q_q;
    qv_d    = qv_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d        = pick;
          gnt_d[pick]  = 1'b1;
          ptr_d        = (pick == IDXW'(N_REQ - 1)) ? '0 : pick + IDXW'(1);
          state_d      = GRANT;
        end
      end
      GRANT: begin
        // Requester withdrew during its grant: drop the write, keep the
        // advanced pointer so it does not get priority again.
        if (REQ[sel_q]) begin
          q_d          = DATA[sel_q*WIDTH +: WIDTH];
          ack_d[sel_q] = 1'b1;
          qv_d         = 1'b1;
          state_d      = RELEASE;
        end else begin
          state_d      = IDLE;
        end
      end
      RELEASE: begin
        if (!REQ[sel_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT     = gnt_q;
  assign ACK     = ack_q;
  assign Q       = q_q;
  assign Q_VALID = qv_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter (N_REQ=4, WIDTH=8).
module tb_reg_write_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic [N_REQ-1:0]       REQ;
  logic [N_REQ*WIDTH-1:0] DATA;
  logic [N_REQ-1:0]       GNT;
  logic [N_REQ-1:0]       ACK;
  logic [WIDTH-1:0]       Q;
  logic                   Q_VALID;
  logic                   BUSY;

  reg_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ     (REQ),
    .DATA    (DATA),
    .GNT     (GNT),
    .ACK     (ACK),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        qv;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input string name, input logic rst, input logic [3:0] req,
                     input logic [31:0] data, input logic [3:0] gnt,
                     input logic [3:0] ack, input logic [7:0] q,
                     input logic qv, input logic busy);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.data = data;
    v.gnt = gnt; v.ack = ack; v.q = q; v.qv = qv; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] gnt, input logic [3:0] ack,
                            input logic [7:0] q, input logic qv, input logic busy);
    chk({tag, ".GNT"},     32'(GNT),     32'(gnt));
    chk({tag, ".ACK"},     32'(ACK),     32'(ack));
    chk({tag, ".Q"},       32'(Q),       32'(q));
    chk({tag, ".Q_VALID"}, 32'(Q_VALID), 32'(qv));
    chk({tag, ".BUSY"},    32'(BUSY),    32'(busy));
    chk({tag, ".GNT_onehot0"}, 32'($onehot0(GNT)), 32'd1);
  endtask

  // Drive inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic [31:0] data);
    @(negedge CLK);
    RESET = rst;
    REQ   = req;
    DATA  = data;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    logic [7:0] qe;
    logic       qve;
    int         g;

    RESET = 1'b1;
    REQ   = '0;
    DATA  = '0;

    // Reset held with all requests high.
    add("rst0", 1'b1, 4'b1111, 32'hDEADBEEF, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    add("rst1", 1'b1, 4'b1111, 32'hDEADBEEF, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);

    // Round robin with all requests held; each requester drops for one
    // cycle after its ACK. Expected grant order 0,1,2,3,0.
    qe  = 8'h00;
    qve = 1'b0;
    for (int k = 0; k < 5; k++) begin
      g  = k % 4;
      oh = 4'b0001 << g;
      add($sformatf("rr%0d_gnt", k), 1'b0, 4'b1111, 32'h13121110, oh, 4'b0000, qe, qve, 1'b1);
      qe  = 8'h10 + 8'(g);
      qve = 1'b1;
      add($sformatf("rr%0d_ack", k), 1'b0, 4'b1111, 32'h13121110, 4'b0000, oh, qe, qve, 1'b1);
      add($sformatf("rr%0d_rel", k), 1'b0, 4'b1111 & ~oh, 32'h13121110, 4'b0000, 4'b0000, qe, qve, 1'b0);
    end

    // Single write by requester 2 (pointer is 1 here); other slices are noise.
    add("sw_gnt",  1'b0, 4'b0100, 32'h77A56655, 4'b0100, 4'b0000, 8'h10, 1'b1, 1'b1);
    add("sw_ack",  1'b0, 4'b0100, 32'h77A56655, 4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b1);
    add("sw_hold", 1'b0, 4'b0100, 32'h77A56655, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b1);
    add("sw_rel",  1'b0, 4'b0000, 32'h77A56655, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0);
    add("sw_idle", 1'b0, 4'b0000, 32'h77A56655, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0);

    // Fairness: grant to 1, then with 0 and 1 requesting, 0 wins first.
    add("fr_g1",   1'b0, 4'b0010, 32'h44332211, 4'b0010, 4'b0000, 8'hA5, 1'b1, 1'b1);
    add("fr_a1",   1'b0, 4'b0010, 32'h44332211, 4'b0000, 4'b0010, 8'h22, 1'b1, 1'b1);
    add("fr_r1",   1'b0, 4'b0000, 32'h44332211, 4'b0000, 4'b0000, 8'h22, 1'b1, 1'b0);
    add("fr_g0",   1'b0, 4'b0011, 32'h44332211, 4'b0001, 4'b0000, 8'h22, 1'b1, 1'b1);
    add("fr_a0",   1'b0, 4'b0011, 32'h44332211, 4'b0000, 4'b0001, 8'h11, 1'b1, 1'b1);
    add("fr_r0",   1'b0, 4'b0010, 32'h44332211, 4'b0000, 4'b0000, 8'h11, 1'b1, 1'b0);
    add("fr_g1b",  1'b0, 4'b0010, 32'h44332211, 4'b0010, 4'b0000, 8'h11, 1'b1, 1'b1);
    add("fr_a1b",  1'b0, 4'b0010, 32'h44332211, 4'b0000, 4'b0010, 8'h22, 1'b1, 1'b1);
    add("fr_r1b",  1'b0, 4'b0000, 32'h44332211, 4'b0000, 4'b0000, 8'h22, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].data);
      check_outs(vecs[i].name, vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].qv, vecs[i].busy);
    end

    // Abort: requester 0 withdraws in its GRANT cycle (pointer is 2 here).
    step(1'b0, 4'b0001, 32'h00005A3C);
    check_outs("ab_gnt",  4'b0001, 4'b0000, 8'h22, 1'b1, 1'b1);
    step(1'b0, 4'b0000, 32'h00005A3C);
    check_outs("ab_drop", 4'b0000, 4'b0000, 8'h22, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 32'h00005A3C);
    check_outs("ab_idle", 4'b0000, 4'b0000, 8'h22, 1'b1, 1'b0);
    // Pointer advanced to 1 by the aborted grant: 1 wins over 0.
    step(1'b0, 4'b0011, 32'h00005A3C);
    check_outs("ab_ptr1", 4'b0010, 4'b0000, 8'h22, 1'b1, 1'b1);
    step(1'b0, 4'b0011, 32'h00005A3C);
    check_outs("ab_ack1", 4'b0000, 4'b0010, 8'h5A, 1'b1, 1'b1);
    step(1'b0, 4'b0000, 32'h00005A3C);
    check_outs("ab_rel1", 4'b0000, 4'b0000, 8'h5A, 1'b1, 1'b0);

    // Reset during the GRANT cycle of a write of 8'hFF by requester 2.
    step(1'b0, 4'b0100, 32'h00FF0000);
    check_outs("mr_gnt",  4'b0100, 4'b0000, 8'h5A, 1'b1, 1'b1);
    step(1'b1, 4'b0100, 32'h00FF0000);
    check_outs("mr_rst",  4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 32'h00FF0000);
    check_outs("mr_idle", 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    // Pointer back to 0 after reset.
    step(1'b0, 4'b1111, 32'h00FF00C3);
    check_outs("mr_ptr0", 4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 32'h00FF00C3);
    check_outs("mr_ack0", 4'b0000, 4'b0001, 8'hC3, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
